// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: scans the voice table per MIDI event and issues one voice write command.
// Optional VOICE_STEAL_EN: a note-on with no free voice steals the oldest held voice instead of dropping.
module midi_voice_alloc #(
   parameter int NUM_VOICES = 8,
   parameter int VIDX_W     = 3
) (
   input  logic                  clk96,
   input  logic                  rst,
   input  logic                  note_pressed,
   input  logic                  note_released,
   input  logic [6:0]            note,
   input  logic [6:0]            velocity,
   input  logic [3:0]            channel,
   output logic                  voice_we,
   output logic [VIDX_W-1:0]     voice_idx,
   output logic [6:0]            voice_note,
   output logic [6:0]            voice_vel,
   output logic                  voice_gate,
   output logic [NUM_VOICES-1:0] voices_active,
   output logic                  busy,
   output logic                  drop
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE} state_t;

   state_t                  state;
   logic [NUM_VOICES-1:0]   v_valid;
   logic [6:0]              v_note  [NUM_VOICES];
   logic [3:0]              v_chan  [NUM_VOICES];
   logic [7:0]              v_stamp [NUM_VOICES];
   logic [7:0]              seq;
   logic [VIDX_W-1:0]       scan_i;

   logic                    cur_off, pend_off, pend_full;
   logic [6:0]              cur_note, cur_vel, pend_note, pend_vel;
   logic [3:0]              cur_chan, pend_chan;

   logic                    free_found, match_found, old_found;
   logic [VIDX_W-1:0]       free_idx, match_idx, old_idx;
   logic [7:0]              old_age;

   logic                    ev, ev_off;
   logic [7:0]              age;
   logic                    alloc_ok;
   logic [VIDX_W-1:0]       alloc_idx;

   assign ev            = note_pressed | note_released;
   assign ev_off        = note_released | (velocity == 7'd0);
   assign age           = seq - v_stamp[scan_i];
   assign voices_active = v_valid;

   always_comb begin
      alloc_ok  = 1'b1;
      alloc_idx = old_idx;
      if (match_found) begin
         alloc_idx = match_idx;
      end else if (free_found) begin
         alloc_idx = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
         alloc_ok  = old_found;
`else
         alloc_ok  = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk96) begin
      if (rst) begin
         state       <= S_IDLE;
         v_valid     <= '0;
         seq         <= '0;
         scan_i      <= '0;
         cur_off     <= 1'b0;
         cur_note    <= '0;
         cur_vel     <= '0;
         cur_chan    <= '0;
         pend_full   <= 1'b0;
         pend_off    <= 1'b0;
         pend_note   <= '0;
         pend_vel    <= '0;
         pend_chan   <= '0;
         free_found  <= 1'b0;
         match_found <= 1'b0;
         old_found   <= 1'b0;
         free_idx    <= '0;
         match_idx   <= '0;
         old_idx     <= '0;
         old_age     <= '0;
         voice_we    <= 1'b0;
         voice_idx   <= '0;
         voice_note  <= '0;
         voice_vel   <= '0;
         voice_gate  <= 1'b0;
         busy        <= 1'b0;
         drop        <= 1'b0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            v_note[i]  <= '0;
            v_chan[i]  <= '0;
            v_stamp[i] <= '0;
         end
      end else begin
         voice_we <= 1'b0;
         drop     <= 1'b0;

         // While busy, new events queue into the single pending slot or are dropped.
         if (state != S_IDLE && ev) begin
            if (pend_full) begin
               drop <= 1'b1;
            end else begin
               pend_full <= 1'b1;
               pend_off  <= ev_off;
               pend_note <= note;
               pend_vel  <= velocity;
               pend_chan <= channel;
            end
         end

         case (state)
            S_IDLE: begin
               free_found  <= 1'b0;
               match_found <= 1'b0;
               old_found   <= 1'b0;
               scan_i      <= '0;
               if (pend_full) begin
                  cur_off  <= pend_off;
                  cur_note <= pend_note;
                  cur_vel  <= pend_vel;
                  cur_chan <= pend_chan;
                  // The slot frees as it is consumed, so a same-cycle event refills it.
                  pend_full <= ev;
                  if (ev) begin
                     pend_off  <= ev_off;
                     pend_note <= note;
                     pend_vel  <= velocity;
                     pend_chan <= channel;
                  end
                  state <= S_SCAN;
                  busy  <= 1'b1;
               end else if (ev) begin
                  cur_off  <= ev_off;
                  cur_note <= note;
                  cur_vel  <= velocity;
                  cur_chan <= channel;
                  state    <= S_SCAN;
                  busy     <= 1'b1;
               end
            end

            S_SCAN: begin
               if (!v_valid[scan_i]) begin
                  if (!free_found) begin
                     free_found <= 1'b1;
                     free_idx   <= scan_i;
                  end
               end else begin
                  if (!match_found && v_note[scan_i] == cur_note && v_chan[scan_i] == cur_chan) begin
                     match_found <= 1'b1;
                     match_idx   <= scan_i;
                  end
                  // Strict compare keeps the lowest index on equal age.
                  if (!old_found || age > old_age) begin
                     old_found <= 1'b1;
                     old_idx   <= scan_i;
                     old_age   <= age;
                  end
               end
               if (scan_i == VIDX_W'(NUM_VOICES - 1)) begin
                  state <= S_WRITE;
               end else begin
                  scan_i <= scan_i + 1'b1;
               end
            end

            S_WRITE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (cur_off) begin
                  if (match_found) begin
                     voice_we           <= 1'b1;
                     voice_idx          <= match_idx;
                     voice_note         <= cur_note;
                     voice_vel          <= '0;
                     voice_gate         <= 1'b0;
                     v_valid[match_idx] <= 1'b0;
                  end
               end else if (alloc_ok) begin
                  voice_we           <= 1'b1;
                  voice_idx          <= alloc_idx;
                  voice_note         <= cur_note;
                  voice_vel          <= cur_vel;
                  voice_gate         <= 1'b1;
                  v_valid[alloc_idx] <= 1'b1;
                  v_note[alloc_idx]  <= cur_note;
                  v_chan[alloc_idx]  <= cur_chan;
                  v_stamp[alloc_idx] <= seq;
                  seq                <= seq + 8'd1;
               end else begin
                  drop <= 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed self-checking bench for midi_voice_alloc (default 8 voices; follows VOICE_STEAL_EN if defined).
module tb_midi_voice_alloc;

   logic       clk96 = 1'b0;
   logic       rst = 1'b1;
   logic       note_pressed = 1'b0, note_released = 1'b0;
   logic [6:0] note = '0, velocity = '0;
   logic [3:0] channel = '0;
   logic       voice_we, voice_gate, busy, drop;
   logic [2:0] voice_idx;
   logic [6:0] voice_note, voice_vel;
   logic [7:0] voices_active;

   int errors = 0;
   int checks = 0;

   int we_cnt = 0, drop_cnt = 0;
   int last_idx, last_note, last_vel, last_gate;
   int hist [256];
   int base_we, base_drop;

   midi_voice_alloc #(.NUM_VOICES(8), .VIDX_W(3)) dut (
      .clk96(clk96), .rst(rst),
      .note_pressed(note_pressed), .note_released(note_released),
      .note(note), .velocity(velocity), .channel(channel),
      .voice_we(voice_we), .voice_idx(voice_idx), .voice_note(voice_note),
      .voice_vel(voice_vel), .voice_gate(voice_gate),
      .voices_active(voices_active), .busy(busy), .drop(drop)
   );

   always #5 clk96 = ~clk96;

   // Command log, sampled on the falling edge.
   always @(negedge clk96) begin
      if (voice_we) begin
         last_idx  = int'(voice_idx);
         last_note = int'(voice_note);
         last_vel  = int'(voice_vel);
         last_gate = int'(voice_gate);
         if (we_cnt < 256) hist[we_cnt] = int'(voice_note);
         we_cnt++;
      end
      if (drop) drop_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic p, input logic r, input int n, input int v, input int c);
      @(negedge clk96);
      note_pressed  = p;
      note_released = r;
      note          = 7'(n);
      velocity      = 7'(v);
      channel       = 4'(c);
      @(negedge clk96);
      note_pressed  = 1'b0;
      note_released = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk96);
   endtask

   task automatic do_reset();
      @(negedge clk96);
      rst = 1'b1;
      settle(2);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      settle(3);
      chk("rst_we", int'(voice_we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop", int'(drop), 0);
      chk("rst_active", int'(voices_active), 0);
      chk("rst_idx", int'(voice_idx), 0);
      rst = 1'b0;

      // First note-on, exact latency
      send(1'b1, 1'b0, 60, 100, 0);
      settle(8);
      chk("lat_we_early", int'(voice_we), 0);
      chk("lat_busy_early", int'(busy), 1);
      settle(1);
      chk("lat_we", int'(voice_we), 1);
      chk("lat_idx", int'(voice_idx), 0);
      chk("lat_note", int'(voice_note), 60);
      chk("lat_vel", int'(voice_vel), 100);
      chk("lat_gate", int'(voice_gate), 1);
      chk("lat_active", int'(voices_active), 8'h01);
      chk("lat_busy_done", int'(busy), 0);
      settle(1);
      chk("we_single", int'(voice_we), 0);

      // Note-off frees a middle voice, then reuse it
      do_reset();
      send(1'b1, 1'b0, 60, 90, 0); settle(12);
      send(1'b1, 1'b0, 62, 90, 0); settle(12);
      send(1'b1, 1'b0, 64, 90, 0); settle(12);
      chk("three_on_idx", last_idx, 2);
      chk("three_on_active", int'(voices_active), 8'h07);
      base_we = we_cnt;
      send(1'b0, 1'b1, 62, 0, 0); settle(12);
      chk("off_cnt", we_cnt - base_we, 1);
      chk("off_idx", last_idx, 1);
      chk("off_gate", last_gate, 0);
      chk("off_vel", last_vel, 0);
      chk("off_active", int'(voices_active), 8'h05);
      send(1'b1, 1'b0, 67, 80, 0); settle(12);
      chk("reuse_idx", last_idx, 1);
      chk("reuse_note", last_note, 67);
      chk("reuse_active", int'(voices_active), 8'h07);

      // Velocity-0 note-on acts as note-off; unmatched note-off is silent
      do_reset();
      send(1'b1, 1'b0, 60, 100, 0); settle(12);
      send(1'b1, 1'b0, 60, 0, 0); settle(12);
      chk("v0_idx", last_idx, 0);
      chk("v0_gate", last_gate, 0);
      chk("v0_active", int'(voices_active), 0);
      base_we = we_cnt; base_drop = drop_cnt;
      send(1'b0, 1'b1, 60, 0, 0); settle(12);
      chk("nomatch_we", we_cnt - base_we, 0);
      chk("nomatch_drop", drop_cnt - base_drop, 0);

      // Same-cycle press and release: release wins
      send(1'b1, 1'b0, 65, 70, 3); settle(12);
      chk("both_on_idx", last_idx, 0);
      send(1'b1, 1'b1, 65, 70, 3); settle(12);
      chk("both_gate", last_gate, 0);
      chk("both_active", int'(voices_active), 0);

      // Fill all voices then one more note-on
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(1'b1, 1'b0, 60 + i, 100, 0);
         settle(12);
      end
      chk("fill_active", int'(voices_active), 8'hFF);
      chk("fill_last_idx", last_idx, 7);
      base_we = we_cnt; base_drop = drop_cnt;
      send(1'b1, 1'b0, 70, 100, 0); settle(12);
`ifdef VOICE_STEAL_EN
      chk("steal_we", we_cnt - base_we, 1);
      chk("steal_idx", last_idx, 0);
      chk("steal_note", last_note, 70);
      chk("steal_gate", last_gate, 1);
      chk("steal_drop", drop_cnt - base_drop, 0);
`else
      chk("full_we", we_cnt - base_we, 0);
      chk("full_drop", drop_cnt - base_drop, 1);
`endif
      chk("full_active", int'(voices_active), 8'hFF);

      // Three back-to-back pulses: two queue, third drops
      do_reset();
      base_we = we_cnt; base_drop = drop_cnt;
      @(negedge clk96);
      note_pressed = 1'b1; velocity = 7'd100; channel = 4'd0;
      note = 7'd60;
      @(negedge clk96);
      note = 7'd61;
      chk("b2b_no_drop1", int'(drop), 0);
      @(negedge clk96);
      note = 7'd62;
      chk("b2b_no_drop2", int'(drop), 0);
      @(negedge clk96);
      note_pressed = 1'b0;
      chk("b2b_drop", int'(drop), 1);
      settle(30);
      chk("b2b_we_cnt", we_cnt - base_we, 2);
      chk("b2b_first", hist[base_we], 60);
      chk("b2b_second", hist[base_we + 1], 61);
      chk("b2b_drop_cnt", drop_cnt - base_drop, 1);
      chk("b2b_active", int'(voices_active), 8'h03);

      // Reset mid-scan aborts without a command
      do_reset();
      base_we = we_cnt;
      send(1'b1, 1'b0, 60, 100, 0);
      settle(3);
      rst = 1'b1;
      @(negedge clk96);
      chk("abort_busy", int'(busy), 0);
      chk("abort_active", int'(voices_active), 0);
      rst = 1'b0;
      settle(15);
      chk("abort_we", we_cnt - base_we, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
